// File: rtl/neuroset_frame_loader_if.sv
// Signal bundle between the frame loader and its host/accelerator side: pixel stream,
// picture-database write port, GO/STOP handshake and result port.
interface neuroset_frame_loader_if #(
  parameter int unsigned SIZE_1           = 11,
  parameter int unsigned SIZE_address_pix = 13
);
  logic                        s_valid;
  logic signed [SIZE_1-1:0]    s_data;
  logic                        s_ready;
  logic                        we_database;
  logic signed [SIZE_1-1:0]    dp_database;
  logic [SIZE_address_pix-1:0] address_p_database;
  logic                        GO;
  logic                        STOP;
  logic [3:0]                  RESULT;
  logic                        res_valid;
  logic [3:0]                  res_data;
  logic                        res_err;
  logic                        res_ready;
  logic                        busy;

  modport master (
    input  s_valid, s_data, STOP, RESULT, res_ready,
    output s_ready, we_database, dp_database, address_p_database, GO,
           res_valid, res_data, res_err, busy
  );

  modport slave (
    output s_valid, s_data, STOP, RESULT, res_ready,
    input  s_ready, we_database, dp_database, address_p_database, GO,
           res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/neuroset_frame_loader.sv
// Loads one picture into the accelerator database, pulses GO, waits for STOP under a
// watchdog and presents the class (or a timeout marker) on a ready/valid result port.
module neuroset_frame_loader #(
  parameter int unsigned SIZE_1           = 11,
  parameter int unsigned picture_size     = 28,
  parameter int unsigned SIZE_address_pix = 13,
  parameter int unsigned GO_LEN           = 1,
  parameter int unsigned TIMEOUT_CYC      = 2000000
) (
  input  logic                   clk,
  input  logic                   rst,
  neuroset_frame_loader_if.master bus
);
  localparam int unsigned Pixels = picture_size * picture_size;
  localparam int unsigned GoW    = $clog2(GO_LEN + 1);
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SIZE_address_pix-1:0] LastPix = SIZE_address_pix'(Pixels - 1);
  localparam logic [GoW-1:0]              GoLast  = GoW'(GO_LEN);
  localparam logic [WdW-1:0]              WdLast  = WdW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StLoad, StStart, StArm, StRun, StReport} state_e;

  state_e                      state_q, state_d;
  logic [SIZE_address_pix-1:0] pix_q, pix_d;
  logic [GoW-1:0]              go_cnt_q, go_cnt_d;
  logic [WdW-1:0]              wd_q, wd_d;
  logic                        we_q, we_d;
  logic signed [SIZE_1-1:0]    dp_q, dp_d;
  logic [SIZE_address_pix-1:0] addr_q, addr_d;
  logic [3:0]                  res_data_q, res_data_d;
  logic                        res_err_q, res_err_d;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    go_cnt_d   = go_cnt_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    dp_d       = dp_q;
    addr_d     = addr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      StLoad: begin
        // s_ready is high throughout LOAD once out of reset, so s_valid alone is a beat
        if (bus.s_valid) begin
          we_d   = 1'b1;
          dp_d   = bus.s_data;
          addr_d = pix_q;
          if (pix_q == LastPix) begin
            pix_d    = '0;
            go_cnt_d = '0;
            state_d  = StStart;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      StStart: begin
        // First START cycle carries the last write; GO follows for GO_LEN cycles
        if (go_cnt_q == GoLast) begin
          wd_d    = '0;
          state_d = StArm;
        end else begin
          go_cnt_d = go_cnt_q + 1'b1;
        end
      end
      StArm: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == WdLast) begin
          res_data_d = 4'hF;
          res_err_d  = 1'b1;
          state_d    = StReport;
        end else if (!bus.STOP) begin
          state_d = StRun;
        end
      end
      StRun: begin
        wd_d = wd_q + 1'b1;
        if (bus.STOP) begin
          res_data_d = bus.RESULT;
          res_err_d  = 1'b0;
          state_d    = StReport;
        end else if (wd_q == WdLast) begin
          res_data_d = 4'hF;
          res_err_d  = 1'b1;
          state_d    = StReport;
        end
      end
      StReport: begin
        if (bus.res_ready) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      pix_q      <= '0;
      go_cnt_q   <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      dp_q       <= '0;
      addr_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      go_cnt_q   <= go_cnt_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      dp_q       <= dp_d;
      addr_q     <= addr_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // rst gates the combinational strobes so a held reset stalls the stream and cuts GO at once
  assign bus.s_ready            = (state_q == StLoad) && !rst;
  assign bus.GO                 = (state_q == StStart) && (go_cnt_q != '0) && !rst;
  assign bus.we_database        = we_q;
  assign bus.dp_database        = dp_q;
  assign bus.address_p_database = addr_q;
  assign bus.res_valid          = (state_q == StReport);
  assign bus.res_data           = res_data_q;
  assign bus.res_err            = res_err_q;
  assign bus.busy               = !((state_q == StLoad) && (pix_q == '0));
endmodule
